ps2_key_decoder: RTL and testbench
==================================

// Module: ps2_key_decoder
// PURPOSE
//  Receives PS/2 keyboard frames from the USB->PS/2 converter outputs (PS2clock/PS2data).
//  Decodes set-2 make/break/E0 sequences, tracks Shift/Caps state and emits US-layout ASCII
//  with a one-cycle strobe. Sits directly upstream of Text_Editor (NewKey/Ascii inputs).
// PARAMETERS
//  CLK_HZ      50_000_000  sys_clk frequency in Hz
//  TIMEOUT_US  200         max PS2Clk idle time inside a frame before the frame is aborted
//  FILTER_LEN  8           consecutive equal samples required to accept a PS2Clk level change
// PORTS
//  sys_clk    in   1  system clock (clk50 domain)
//  sys_rst_n  in   1  asynchronous active-low reset
//  PS2Clk     in   1  PS/2 clock (async, idle high)
//  PS2Data    in   1  PS/2 data (async, idle high)
//  Result     out  8  ASCII of last decoded key; held until next NewKey
//  NewKey     out  1  one-cycle strobe: Result valid this cycle
//  ScanCode   out  8  last accepted make code (raw, without prefix)
//  Extended   out  1  1 if ScanCode was E0-prefixed
//  FrameErr   out  1  one-cycle pulse on parity, stop-bit or timeout error
// BEHAVIOUR
//  Reset (async, sys_rst_n=0): all outputs 0; FSM IDLE; shift_l/shift_r/caps/caps_held/ext/brk cleared.
//   Reset mid-frame discards partial bits.
//  Input path: 2-FF sync on both lines. Filtered clock changes only after FILTER_LEN equal samples.
//   Falling edge of filtered clock = bit strobe; synced PS2Data sampled on that cycle.
//  Frame FSM: IDLE -> DATA -> PARITY -> STOP -> IDLE.
//   - IDLE: strobe with data=0 -> DATA. Strobe with data=1 is ignored.
//   - DATA: 8 bits, LSB first, 3-bit counter -> PARITY after bit 7.
//   - PARITY: data bits plus parity bit must have an odd number of ones.
//   - STOP: bit must be 1.
//   - Success: byte_valid pulses for 1 cycle (cycle N after the stop strobe).
//   - Parity or stop failure: FrameErr pulses, FSM -> IDLE, ext/brk cleared, byte dropped.
//  Timeout: counter = CLK_HZ/1_000_000*TIMEOUT_US cycles; reloads on every filtered edge.
//   - On expiry while not IDLE: FSM -> IDLE, FrameErr pulses, ext/brk cleared.
//   - Edge and expiry in the same cycle: the edge wins.
//  Byte decode (on byte_valid):
//   - E0: set ext. F0: set brk. No output for either.
//   - Other byte with brk=1 (release): 12 clears shift_l; 59 clears shift_r; 58 clears caps_held.
//     Clears ext/brk. No NewKey.
//   - Other byte, make: ScanCode<=byte, Extended<=ext.
//     - 12/59 set shift_l/shift_r.
//     - 58: toggles caps only if caps_held=0, then sets caps_held (typematic repeat does not re-toggle).
//     - Else ASCII lookup; if mapped, Result<=code and NewKey=1 at cycle N+1.
//     - ext/brk cleared afterwards.
//  ASCII map (US, set 2):
//   - Letters 1C..(a-z): uppercase iff shift XOR caps.
//   - Digit row and punctuation: shifted form iff shift (caps ignored).
//   - 29->20, 5A->0D, 66->08, 76->1B, 0D->09.
//   - E0 5A->0D; E0 4A->2F. All other E0 codes and unmapped codes produce no NewKey.
//   - shift = shift_l | shift_r.
//  Latency: stop-bit strobe -> byte_valid at +1 cycle -> NewKey at +2 cycles.
//   Back-to-back bytes are naturally >=60 us apart; no buffering is required.
// TESTING
//  1. Frame 0x1C (parity 0, stop 1) -> exactly one NewKey, Result=0x61, ScanCode=0x1C, Extended=0.
//  2. 12,1C,F0,1C,F0,12 -> single NewKey with Result=0x41; then 1C -> 0x61 (shift released).
//  3. 58,F0,58 then 16,1C -> Result 0x31 then 0x41; a second 58,58 (repeat) toggles caps only once.
//  4. 0x1C sent with parity=1 -> FrameErr pulse, no NewKey; next good 0x32 frame -> Result=0x62.
//  5. Start + 5 data bits, then PS2Clk idle >TIMEOUT_US -> FrameErr pulse, FSM IDLE;
//     following 0x1C frame decodes to 0x61.
//  6. 3-cycle low glitch on PS2Clk -> no bit taken. E0,5A -> Result=0x0D, Extended=1.
//     sys_rst_n low mid-frame -> all outputs 0.

Source files
------------

// File: rtl/ps2_key_decoder.sv
`default_nettype none
// ============================================================================
// Module      : ps2_key_decoder
// Description : PS/2 set-2 keyboard receiver with Shift/Caps tracking and
//               US-layout ASCII output strobed by NewKey.
// Revision    : 1.0 - initial release
// ============================================================================
module ps2_key_decoder #(
   parameter int CLK_HZ     = 50_000_000,
   parameter int TIMEOUT_US = 200,
   parameter int FILTER_LEN = 8
) (
   input  logic       sys_clk,
   input  logic       sys_rst_n,
   input  logic       PS2Clk,
   input  logic       PS2Data,
   output logic [7:0] Result,
   output logic       NewKey,
   output logic [7:0] ScanCode,
   output logic       Extended,
   output logic       FrameErr
);

   localparam int c_TO_CYC = CLK_HZ / 1_000_000 * TIMEOUT_US;
   localparam int c_TO_W   = $clog2(c_TO_CYC + 1);
   localparam int c_FLT_W  = $clog2(FILTER_LEN + 1);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_DATA   = 2'd1,
      S_PARITY = 2'd2,
      S_STOP   = 2'd3
   } state_t;

   state_t              r_state, w_state_nx;
   logic [1:0]          r_clk_s, r_dat_s;
   logic                r_clk_filt, r_clk_filt_d;
   logic [c_FLT_W-1:0]  r_flt_cnt;
   logic [c_TO_W-1:0]   r_to_cnt;
   logic [7:0]          r_sreg;
   logic [2:0]          r_bitcnt;
   logic                r_byte_valid, r_frame_err;
   logic                r_shift_l, r_shift_r, r_caps, r_caps_held, r_ext, r_brk;
   logic [7:0]          r_result, r_scancode;
   logic                r_newkey, r_extended;

   logic                w_edge, w_strobe, w_bit, w_timeout;
   logic                w_byte_ok, w_frm_err;
   logic                w_shift, w_letter, w_map, w_use_up;
   logic [7:0]          w_lc, w_up, w_ascii;

   assign w_edge    = r_clk_filt ^ r_clk_filt_d;
   assign w_strobe  = r_clk_filt_d & ~r_clk_filt;
   assign w_bit     = r_dat_s[1];
   assign w_timeout = (r_state != S_IDLE) && !w_edge && (r_to_cnt == '0);

   // Synchronisers reset high so an idle bus produces no spurious edge.
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         r_clk_s      <= 2'b11;
         r_dat_s      <= 2'b11;
         r_clk_filt   <= 1'b1;
         r_clk_filt_d <= 1'b1;
         r_flt_cnt    <= '0;
         r_to_cnt     <= c_TO_W'(c_TO_CYC - 1);
      end else begin
         r_clk_s      <= {r_clk_s[0], PS2Clk};
         r_dat_s      <= {r_dat_s[0], PS2Data};
         r_clk_filt_d <= r_clk_filt;
         if (r_clk_s[1] != r_clk_filt) begin
            if (r_flt_cnt == c_FLT_W'(FILTER_LEN - 1)) begin
               r_clk_filt <= r_clk_s[1];
               r_flt_cnt  <= '0;
            end else begin
               r_flt_cnt <= r_flt_cnt + 1'b1;
            end
         end else begin
            r_flt_cnt <= '0;
         end
         if (r_state == S_IDLE || w_edge)
            r_to_cnt <= c_TO_W'(c_TO_CYC - 1);
         else if (r_to_cnt != '0)
            r_to_cnt <= r_to_cnt - 1'b1;
      end
   end

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) r_state <= S_IDLE;
      else            r_state <= w_state_nx;
   end

   always_comb begin
      w_state_nx = r_state;
      w_byte_ok  = 1'b0;
      w_frm_err  = 1'b0;
      if (w_timeout) begin
         w_state_nx = S_IDLE;
         w_frm_err  = 1'b1;
      end else if (w_strobe) begin
         case (r_state)
            S_IDLE:   if (!w_bit) w_state_nx = S_DATA;
            S_DATA:   if (r_bitcnt == 3'd7) w_state_nx = S_PARITY;
            S_PARITY: begin
               if ((^r_sreg) ^ w_bit) begin
                  w_state_nx = S_STOP;
               end else begin
                  w_state_nx = S_IDLE;
                  w_frm_err  = 1'b1;
               end
            end
            S_STOP: begin
               w_state_nx = S_IDLE;
               w_byte_ok  = w_bit;
               w_frm_err  = !w_bit;
            end
            default:  w_state_nx = S_IDLE;
         endcase
      end
   end

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         r_sreg       <= '0;
         r_bitcnt     <= '0;
         r_byte_valid <= 1'b0;
         r_frame_err  <= 1'b0;
      end else begin
         r_byte_valid <= w_byte_ok;
         r_frame_err  <= w_frm_err;
         if (r_state == S_IDLE) begin
            r_bitcnt <= '0;
         end else if (w_strobe && r_state == S_DATA) begin
            r_sreg   <= {w_bit, r_sreg[7:1]};
            r_bitcnt <= r_bitcnt + 1'b1;
         end
      end
   end

   // Letters set only w_lc; keys with a distinct shifted glyph set both.
   assign w_shift = r_shift_l | r_shift_r;
   always_comb begin
      w_lc = 8'h00;
      w_up = 8'h00;
      case ({r_ext, r_sreg})
         9'h01C: w_lc = "a";  9'h032: w_lc = "b";  9'h021: w_lc = "c";
         9'h023: w_lc = "d";  9'h024: w_lc = "e";  9'h02B: w_lc = "f";
         9'h034: w_lc = "g";  9'h033: w_lc = "h";  9'h043: w_lc = "i";
         9'h03B: w_lc = "j";  9'h042: w_lc = "k";  9'h04B: w_lc = "l";
         9'h03A: w_lc = "m";  9'h031: w_lc = "n";  9'h044: w_lc = "o";
         9'h04D: w_lc = "p";  9'h015: w_lc = "q";  9'h02D: w_lc = "r";
         9'h01B: w_lc = "s";  9'h02C: w_lc = "t";  9'h03C: w_lc = "u";
         9'h02A: w_lc = "v";  9'h01D: w_lc = "w";  9'h022: w_lc = "x";
         9'h035: w_lc = "y";  9'h01A: w_lc = "z";
         9'h016: begin w_lc = "1"; w_up = "!"; end
         9'h01E: begin w_lc = "2"; w_up = "@"; end
         9'h026: begin w_lc = "3"; w_up = "#"; end
         9'h025: begin w_lc = "4"; w_up = "$"; end
         9'h02E: begin w_lc = "5"; w_up = "%"; end
         9'h036: begin w_lc = "6"; w_up = "^"; end
         9'h03D: begin w_lc = "7"; w_up = "&"; end
         9'h03E: begin w_lc = "8"; w_up = "*"; end
         9'h046: begin w_lc = "9"; w_up = "("; end
         9'h045: begin w_lc = "0"; w_up = ")"; end
         9'h00E: begin w_lc = 8'h60; w_up = "~"; end
         9'h04E: begin w_lc = "-"; w_up = "_"; end
         9'h055: begin w_lc = "="; w_up = "+"; end
         9'h054: begin w_lc = "["; w_up = "{"; end
         9'h05B: begin w_lc = "]"; w_up = "}"; end
         9'h05D: begin w_lc = 8'h5C; w_up = "|"; end
         9'h04C: begin w_lc = ";"; w_up = ":"; end
         9'h052: begin w_lc = "'"; w_up = 8'h22; end
         9'h041: begin w_lc = ","; w_up = "<"; end
         9'h049: begin w_lc = "."; w_up = ">"; end
         9'h04A: begin w_lc = "/"; w_up = "?"; end
         9'h029: w_lc = 8'h20;
         9'h05A: w_lc = 8'h0D;
         9'h066: w_lc = 8'h08;
         9'h076: w_lc = 8'h1B;
         9'h00D: w_lc = 8'h09;
         9'h15A: w_lc = 8'h0D;
         9'h14A: w_lc = 8'h2F;
         default: w_lc = 8'h00;
      endcase
      w_letter = (w_lc >= 8'h61) && (w_lc <= 8'h7A);
      w_map    = (w_lc != 8'h00);
      if (w_up == 8'h00)
         w_up = w_letter ? (w_lc - 8'h20) : w_lc;
      w_use_up = w_letter ? (w_shift ^ r_caps) : w_shift;
      w_ascii  = w_use_up ? w_up : w_lc;
   end

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         r_shift_l   <= 1'b0;
         r_shift_r   <= 1'b0;
         r_caps      <= 1'b0;
         r_caps_held <= 1'b0;
         r_ext       <= 1'b0;
         r_brk       <= 1'b0;
         r_result    <= '0;
         r_newkey    <= 1'b0;
         r_scancode  <= '0;
         r_extended  <= 1'b0;
      end else begin
         r_newkey <= 1'b0;
         if (w_frm_err) begin
            r_ext <= 1'b0;
            r_brk <= 1'b0;
         end else if (r_byte_valid) begin
            if (r_sreg == 8'hE0) begin
               r_ext <= 1'b1;
            end else if (r_sreg == 8'hF0) begin
               r_brk <= 1'b1;
            end else begin
               r_ext <= 1'b0;
               r_brk <= 1'b0;
               if (r_brk) begin
                  case (r_sreg)
                     8'h12:   r_shift_l   <= 1'b0;
                     8'h59:   r_shift_r   <= 1'b0;
                     8'h58:   r_caps_held <= 1'b0;
                     default: ;
                  endcase
               end else begin
                  r_scancode <= r_sreg;
                  r_extended <= r_ext;
                  case (r_sreg)
                     8'h12: r_shift_l <= 1'b1;
                     8'h59: r_shift_r <= 1'b1;
                     // Typematic repeats of Caps keep caps_held set and do not re-toggle.
                     8'h58: begin
                        if (!r_caps_held) r_caps <= ~r_caps;
                        r_caps_held <= 1'b1;
                     end
                     default: begin
                        if (w_map) begin
                           r_result <= w_ascii;
                           r_newkey <= 1'b1;
                        end
                     end
                  endcase
               end
            end
         end
      end
   end

   assign Result   = r_result;
   assign NewKey   = r_newkey;
   assign ScanCode = r_scancode;
   assign Extended = r_extended;
   assign FrameErr = r_frame_err;

endmodule
`default_nettype wire

// File: tb/tb_ps2_key_decoder.sv
`default_nettype none
// ============================================================================
// Module      : tb_ps2_key_decoder
// Description : Self-checking bench: table of PS/2 frames, scoreboard of keys.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ps2_key_decoder;

   localparam int c_HALF = 30;
   localparam int c_GAP  = 60;

   logic       clk   = 1'b0;
   logic       rst_n = 1'b0;
   logic       ps2c  = 1'b1;
   logic       ps2d  = 1'b1;
   logic [7:0] Result, ScanCode;
   logic       NewKey, Extended, FrameErr;

   always #5 clk = ~clk;

   ps2_key_decoder #(
      .CLK_HZ    (1_000_000),
      .TIMEOUT_US(200),
      .FILTER_LEN(8)
   ) u_dut (
      .sys_clk  (clk),
      .sys_rst_n(rst_n),
      .PS2Clk   (ps2c),
      .PS2Data  (ps2d),
      .Result   (Result),
      .NewKey   (NewKey),
      .ScanCode (ScanCode),
      .Extended (Extended),
      .FrameErr (FrameErr)
   );

   typedef struct {
      logic [7:0] res;
      logic [7:0] sc;
      logic       ext;
   } exp_t;

   typedef struct {
      logic [7:0] data;
      bit         bad_par;
      bit         bad_stop;
      bit         key;
      logic [7:0] res;
      bit         ext;
      int         err;
   } vec_t;

   localparam int c_NVEC = 32;
   vec_t tbl [c_NVEC];
   exp_t q [$];
   exp_t m_e;
   int   n_checks = 0, n_errors = 0, err_cnt = 0, key_cnt = 0, exp_keys = 0;

   task automatic chk(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (FrameErr) err_cnt++;
      if (NewKey) begin
         key_cnt++;
         if (q.size() == 0) begin
            chk("unexpected NewKey", 1, 0);
         end else begin
            m_e = q.pop_front();
            chk("Result", int'(Result), int'(m_e.res));
            chk("ScanCode", int'(ScanCode), int'(m_e.sc));
            chk("Extended", int'(Extended), int'(m_e.ext));
         end
      end
   end

   task automatic ps2_bit(input bit b);
      ps2d = b;
      repeat (c_HALF) @(posedge clk);
      ps2c = 1'b0;
      repeat (c_HALF) @(posedge clk);
      ps2c = 1'b1;
   endtask

   task automatic send_frame(input logic [7:0] d, input bit bad_par, input bit bad_stop);
      ps2_bit(1'b0);
      for (int i = 0; i < 8; i++) ps2_bit(d[i]);
      ps2_bit(~(^d) ^ bad_par);
      ps2_bit(~bad_stop);
      ps2d = 1'b1;
      repeat (c_GAP) @(posedge clk);
   endtask

   task automatic apply(input vec_t v, input int idx);
      int   e0;
      exp_t t;
      e0 = err_cnt;
      if (v.key) begin
         t.res = v.res; t.sc = v.data; t.ext = v.ext;
         q.push_back(t);
         exp_keys++;
      end
      send_frame(v.data, v.bad_par, v.bad_stop);
      chk($sformatf("vec%0d FrameErr count", idx), err_cnt - e0, v.err);
      chk($sformatf("vec%0d pending keys", idx), q.size(), 0);
   endtask

   function automatic vec_t mk(input logic [7:0] d, input bit bp, input bit bs,
                               input bit key, input logic [7:0] res, input bit ext,
                               input int err);
      vec_t v;
      v.data = d; v.bad_par = bp; v.bad_stop = bs;
      v.key = key; v.res = res; v.ext = ext; v.err = err;
      return v;
   endfunction

   task automatic chk_outputs_zero();
      chk("reset Result", int'(Result), 0);
      chk("reset NewKey", int'(NewKey), 0);
      chk("reset ScanCode", int'(ScanCode), 0);
      chk("reset Extended", int'(Extended), 0);
      chk("reset FrameErr", int'(FrameErr), 0);
   endtask

   initial begin
      int e0;
      tbl[0]  = mk(8'h1C, 0, 0, 1, 8'h61, 0, 0);
      tbl[1]  = mk(8'h12, 0, 0, 0, 8'h00, 0, 0);
      tbl[2]  = mk(8'h1C, 0, 0, 1, 8'h41, 0, 0);
      tbl[3]  = mk(8'hF0, 0, 0, 0, 8'h00, 0, 0);
      tbl[4]  = mk(8'h1C, 0, 0, 0, 8'h00, 0, 0);
      tbl[5]  = mk(8'hF0, 0, 0, 0, 8'h00, 0, 0);
      tbl[6]  = mk(8'h12, 0, 0, 0, 8'h00, 0, 0);
      tbl[7]  = mk(8'h1C, 0, 0, 1, 8'h61, 0, 0);
      tbl[8]  = mk(8'h58, 0, 0, 0, 8'h00, 0, 0);
      tbl[9]  = mk(8'hF0, 0, 0, 0, 8'h00, 0, 0);
      tbl[10] = mk(8'h58, 0, 0, 0, 8'h00, 0, 0);
      tbl[11] = mk(8'h16, 0, 0, 1, 8'h31, 0, 0);
      tbl[12] = mk(8'h1C, 0, 0, 1, 8'h41, 0, 0);
      tbl[13] = mk(8'h58, 0, 0, 0, 8'h00, 0, 0);
      tbl[14] = mk(8'h58, 0, 0, 0, 8'h00, 0, 0);
      tbl[15] = mk(8'h1C, 0, 0, 1, 8'h61, 0, 0);
      tbl[16] = mk(8'hF0, 0, 0, 0, 8'h00, 0, 0);
      tbl[17] = mk(8'h58, 0, 0, 0, 8'h00, 0, 0);
      tbl[18] = mk(8'h1C, 1, 0, 0, 8'h00, 0, 1);
      tbl[19] = mk(8'h32, 0, 0, 1, 8'h62, 0, 0);
      tbl[20] = mk(8'h1C, 0, 1, 0, 8'h00, 0, 1);
      tbl[21] = mk(8'h59, 0, 0, 0, 8'h00, 0, 0);
      tbl[22] = mk(8'h16, 0, 0, 1, 8'h21, 0, 0);
      tbl[23] = mk(8'h4A, 0, 0, 1, 8'h3F, 0, 0);
      tbl[24] = mk(8'hF0, 0, 0, 0, 8'h00, 0, 0);
      tbl[25] = mk(8'h59, 0, 0, 0, 8'h00, 0, 0);
      tbl[26] = mk(8'h29, 0, 0, 1, 8'h20, 0, 0);
      tbl[27] = mk(8'hE0, 0, 0, 0, 8'h00, 0, 0);
      tbl[28] = mk(8'h4A, 0, 0, 1, 8'h2F, 1, 0);
      tbl[29] = mk(8'hE0, 0, 0, 0, 8'h00, 0, 0);
      tbl[30] = mk(8'h75, 0, 0, 0, 8'h00, 0, 0);
      tbl[31] = mk(8'h0D, 0, 0, 1, 8'h09, 0, 0);

      repeat (5) @(negedge clk);
      chk_outputs_zero();
      rst_n = 1'b1;
      repeat (c_GAP) @(posedge clk);

      for (int i = 0; i < c_NVEC; i++) begin
         apply(tbl[i], i);
         if (tbl[i].data == 8'h75) begin
            chk("unmapped E0 ScanCode", int'(ScanCode), 8'h75);
            chk("unmapped E0 Extended", int'(Extended), 1);
         end
      end

      // Truncated frame left idle must abort via the timeout.
      e0 = err_cnt;
      ps2_bit(1'b0);
      for (int i = 0; i < 5; i++) ps2_bit(1'b1);
      ps2d = 1'b1;
      repeat (300) @(posedge clk);
      chk("timeout FrameErr count", err_cnt - e0, 1);
      apply(mk(8'h1C, 0, 0, 1, 8'h61, 0, 0), 100);

      // Short low glitch on the clock must not start a frame.
      ps2d = 1'b0;
      ps2c = 1'b0;
      repeat (3) @(posedge clk);
      ps2c = 1'b1;
      ps2d = 1'b1;
      repeat (c_GAP) @(posedge clk);
      apply(mk(8'hE0, 0, 0, 0, 8'h00, 0, 0), 101);
      apply(mk(8'h5A, 0, 0, 1, 8'h0D, 1, 0), 102);

      // Reset in the middle of a frame.
      ps2_bit(1'b0);
      ps2_bit(1'b1);
      ps2_bit(1'b0);
      @(negedge clk);
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      chk_outputs_zero();
      ps2c  = 1'b1;
      ps2d  = 1'b1;
      rst_n = 1'b1;
      repeat (c_GAP) @(posedge clk);
      apply(mk(8'h1C, 0, 0, 1, 8'h61, 0, 0), 103);

      chk("total NewKey count", key_cnt, exp_keys);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
`default_nettype wire
